// File: rtl/sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module   : sd_spi_card_responder
// Brief    : SPI-mode SD card model answering CMD0/8/55/ACMD41/58 after NCR.
// Revision : 1.0 - initial release
// ============================================================================
module sd_spi_card_responder #(
  parameter int          NCR       = 2,
  parameter int          BUSY_CNT  = 3,
  parameter bit          CHECK_CRC = 1'b1,
  parameter logic [31:0] OCR       = 32'hC0FF8000
) (
  input  logic        SD_CLK,
  input  logic        rst,
  input  logic        SD_CS,
  input  logic        SD_DATAIN,
  output logic        SD_DATAOUT,
  output logic        card_idle,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_RX   = 2'd1;
  localparam logic [1:0] S_NCR  = 2'd2;
  localparam logic [1:0] S_TX   = 2'd3;

  localparam logic [3:0] C_NCR  = 4'(NCR);
  localparam logic [3:0] C_BUSY = 4'(BUSY_CNT);

  logic [1:0]  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  ncr_cnt_q, ncr_cnt_d;
  logic [47:0] frame_q, frame_d;
  logic [39:0] resp_q, resp_d;
  logic        resp_long_q, resp_long_d;
  logic        miso_q, miso_d;
  logic        idle_q, idle_d;
  logic [3:0]  busy_q, busy_d;
  logic        app_q, app_d;
  logic        valid_q, valid_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic        crc_err_q, crc_err_d;

  logic        w_abort, w_start, w_rx_done, w_frame_ok, w_decode, w_ncr_done, w_tx_last;
  logic [5:0]  w_idx;
  logic [31:0] w_arg;
  logic        w_crc_bad, w_illegal, w_idle_after, w_app_next, w_long;
  logic [3:0]  w_busy_next;
  logic [31:0] w_tail;
  logic [7:0]  w_r1;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign w_abort    = SD_CS && (state_q != S_WAIT);
  assign w_start    = (state_q == S_WAIT) && !SD_CS && !SD_DATAIN;
  assign w_rx_done  = (state_q == S_RX) && (bit_cnt_q == 6'd0);
  // frame_q has not yet absorbed bit 0, so frame bit 46 still sits at [45]
  assign w_frame_ok = frame_q[45] && SD_DATAIN;
  assign w_decode   = (state_q == S_NCR) && (ncr_cnt_q == C_NCR);
  assign w_ncr_done = (state_q == S_NCR) && (ncr_cnt_q == 4'd0);
  assign w_tx_last  = (state_q == S_TX) && (bit_cnt_q == 6'd0);

  always_comb begin
    w_idx        = frame_q[45:40];
    w_arg        = frame_q[39:8];
    w_crc_bad    = CHECK_CRC && ((w_idx == 6'd0) || (w_idx == 6'd8)) &&
                   (crc7(frame_q[47:8]) != frame_q[7:1]);
    w_illegal    = 1'b0;
    w_idle_after = idle_q;
    w_busy_next  = busy_q;
    w_app_next   = app_q;
    w_long       = 1'b0;
    w_tail       = 32'h0;
    if (!w_crc_bad) begin
      w_app_next = 1'b0;
      case (w_idx)
        6'd0: begin
          w_idle_after = 1'b1;
          w_busy_next  = C_BUSY;
        end
        6'd8: begin
          w_long = 1'b1;
          w_tail = {4'h0, 16'h0, (w_arg[11:8] == 4'b0001) ? 4'b0001 : 4'b0000, w_arg[7:0]};
        end
        6'd55: w_app_next = 1'b1;
        6'd41: begin
          if (!app_q)                w_illegal    = 1'b1;
          else if (busy_q == 4'd0)   w_idle_after = 1'b0;
          else                       w_busy_next  = busy_q - 4'd1;
        end
        6'd58: begin
          w_long = 1'b1;
          w_tail = {OCR[31] & ~idle_q, OCR[30:0]};
        end
        default: w_illegal = 1'b1;
      endcase
    end
    w_r1 = {4'b0000, w_crc_bad, w_illegal, 1'b0, w_idle_after};
  end

  always_ff @(posedge SD_CLK) begin
    if (rst) begin
      state_q     <= S_WAIT;
      bit_cnt_q   <= 6'd0;
      ncr_cnt_q   <= 4'd0;
      frame_q     <= 48'h0;
      resp_q      <= {40{1'b1}};
      resp_long_q <= 1'b0;
      miso_q      <= 1'b1;
      idle_q      <= 1'b1;
      busy_q      <= C_BUSY;
      app_q       <= 1'b0;
      valid_q     <= 1'b0;
      index_q     <= 6'd0;
      arg_q       <= 32'h0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ncr_cnt_q   <= ncr_cnt_d;
      frame_q     <= frame_d;
      resp_q      <= resp_d;
      resp_long_q <= resp_long_d;
      miso_q      <= miso_d;
      idle_q      <= idle_d;
      busy_q      <= busy_d;
      app_q       <= app_d;
      valid_q     <= valid_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
      crc_err_q   <= crc_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_abort) begin
      state_d = S_WAIT;
    end else begin
      case (state_q)
        S_WAIT:  if (w_start)    state_d = S_RX;
        S_RX:    if (w_rx_done)  state_d = w_frame_ok ? S_NCR : S_WAIT;
        S_NCR:   if (w_ncr_done) state_d = S_TX;
        S_TX:    if (w_tx_last)  state_d = S_WAIT;
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    ncr_cnt_d   = ncr_cnt_q;
    frame_d     = frame_q;
    resp_d      = resp_q;
    resp_long_d = resp_long_q;
    miso_d      = 1'b1;
    idle_d      = idle_q;
    busy_d      = busy_q;
    app_d       = app_q;
    valid_d     = 1'b0;
    index_d     = index_q;
    arg_d       = arg_q;
    crc_err_d   = crc_err_q;
    if (!w_abort) begin
      case (state_q)
        S_WAIT: begin
          if (w_start) begin
            frame_d   = {47'h0, SD_DATAIN};
            bit_cnt_d = 6'd46;
          end
        end
        S_RX: begin
          frame_d = {frame_q[46:0], SD_DATAIN};
          if (w_rx_done) ncr_cnt_d = C_NCR;
          else           bit_cnt_d = bit_cnt_q - 6'd1;
        end
        S_NCR: begin
          // Decode on the first gap clock so a CS abort right after the frame cancels it
          if (w_decode) begin
            valid_d     = 1'b1;
            index_d     = w_idx;
            arg_d       = w_arg;
            crc_err_d   = w_crc_bad;
            idle_d      = w_idle_after;
            busy_d      = w_busy_next;
            app_d       = w_app_next;
            resp_long_d = w_long;
            resp_d      = {w_r1, w_tail};
          end
          if (w_ncr_done) begin
            miso_d    = resp_q[39];
            resp_d    = {resp_q[38:0], 1'b1};
            bit_cnt_d = resp_long_q ? 6'd38 : 6'd6;
          end else begin
            ncr_cnt_d = ncr_cnt_q - 4'd1;
          end
        end
        S_TX: begin
          miso_d = resp_q[39];
          resp_d = {resp_q[38:0], 1'b1};
          if (!w_tx_last) bit_cnt_d = bit_cnt_q - 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign SD_DATAOUT = miso_q;
  assign card_idle  = idle_q;
  assign cmd_valid  = valid_q;
  assign cmd_index  = index_q;
  assign cmd_arg    = arg_q;
  assign crc_err    = crc_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_spi_card_responder
// Brief    : Self-checking bench for the SPI SD card responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_spi_card_responder;

  localparam int          NCR   = 2;
  localparam int          BUSY  = 3;
  localparam bit          CHK   = 1'b1;
  localparam logic [31:0] OCR_V = 32'hC0FF8000;

  logic        clk = 1'b0;
  logic        rst, cs, din;
  logic        miso, idle, cv, ce;
  logic [5:0]  cidx;
  logic [31:0] carg;

  int checks   = 0;
  int failures = 0;

  bit          m_idle;
  int          m_busy;
  bit          m_app;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;
  bit          m_ce;

  sd_spi_card_responder #(
    .NCR(NCR), .BUSY_CNT(BUSY), .CHECK_CRC(CHK), .OCR(OCR_V)
  ) dut (
    .SD_CLK(clk), .rst(rst), .SD_CS(cs), .SD_DATAIN(din),
    .SD_DATAOUT(miso), .card_idle(idle), .cmd_valid(cv),
    .cmd_index(cidx), .cmd_arg(carg), .crc_err(ce)
  );

  always #5 clk = ~clk;

  // CRC7 as the remainder of polynomial long division by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg, input bit good);
    logic [6:0] c;
    c = ref_crc7({2'b01, idx, arg});
    if (!good) c = c ^ 7'h5A;
    return {2'b01, idx, arg, c, 1'b1};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_busy = BUSY; m_app = 1'b0;
    m_idx = 6'd0;  m_arg = 32'h0; m_ce = 1'b0;
  endtask

  // Card behaviour per accepted frame; returns the left-aligned response and its length (0 = silent)
  task automatic model_cmd(input logic [47:0] f, output logic [39:0] r, output int n);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic [3:0]  vhs;
    bit          bad, ill;
    r = 40'h0; n = 0;
    if (!(f[46] && f[0])) return;
    idx = f[45:40]; arg = f[39:8];
    bad = CHK && (idx == 6'd0 || idx == 6'd8) && (ref_crc7(f[47:8]) != f[7:1]);
    m_idx = idx; m_arg = arg; m_ce = bad; ill = 1'b0; n = 8;
    if (!bad) begin
      if (idx == 6'd0) begin
        m_idle = 1'b1; m_busy = BUSY;
      end else if (idx == 6'd41 && m_app) begin
        if (m_busy == 0) m_idle = 1'b0;
        else             m_busy = m_busy - 1;
      end else if (idx != 6'd8 && idx != 6'd55 && idx != 6'd58) begin
        ill = 1'b1;
      end
      m_app = (idx == 6'd55);
    end
    r1 = {4'b0, bad, ill, 1'b0, m_idle};
    if (!bad && idx == 6'd8) begin
      vhs = (arg[11:8] == 4'h1) ? 4'h1 : 4'h0;
      r = {r1, 4'h0, 16'h0, vhs, arg[7:0]}; n = 40;
    end else if (!bad && idx == 6'd58) begin
      r = {r1, m_idle ? {1'b0, OCR_V[30:0]} : OCR_V}; n = 40;
    end else begin
      r = {r1, 32'h0};
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; cs = 1'b1; din = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Sends one frame and checks the whole response window cycle by cycle.
  // skip_start: start bit already sampled by the previous call; b2b_out: start the next frame at the earliest edge.
  task automatic xfer(input string name, input logic [47:0] f, input bit skip_start,
                      input bit b2b_out, output logic [39:0] got);
    logic [39:0] er;
    logic [63:0] gm, em, gcv, ecv;
    logic        idle0, idle1, ce1;
    logic [5:0]  idx1;
    logic [31:0] arg1;
    bit          pre_idle, frame_hi;
    int          n, nb, w;
    pre_idle = m_idle;
    model_cmd(f, er, n);
    nb = (n == 0) ? 8 : n;
    w  = NCR + nb + 1;
    gm = '0; em = '0; gcv = '0; ecv = '0; got = '0;
    idle0 = 1'b0; idle1 = 1'b0; ce1 = 1'b0; idx1 = '0; arg1 = '0;
    frame_hi = 1'b1;
    for (int i = (skip_start ? 46 : 47); i >= 0; i--) begin
      cs = 1'b0; din = f[i];
      @(negedge clk);
      if (miso !== 1'b1) frame_hi = 1'b0;
    end
    for (int t = 0; t < w; t++) begin
      gm[t]  = miso;
      gcv[t] = cv;
      em[t]  = (n == 0 || t <= NCR) ? 1'b1 : er[39 - (t - NCR - 1)];
      ecv[t] = (n != 0 && t == 1);
      if (t == 0) idle0 = idle;
      if (t == 1) begin idle1 = idle; idx1 = cidx; arg1 = carg; ce1 = ce; end
      cs = 1'b0; din = (b2b_out && t == w - 1) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    for (int j = 0; j < nb; j++) got[39 - j] = gm[NCR + 1 + j];

    checks++; if (!frame_hi) begin failures++; $display("FAIL %s miso_during_frame got=0 exp=1", name); end
    checks++; if (gm !== em) begin failures++; $display("FAIL %s miso_window got=%h exp=%h", name, gm, em); end
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL %s miso_after got=%b exp=1", name, miso); end
    checks++; if (gcv !== ecv) begin failures++; $display("FAIL %s cmd_valid got=%h exp=%h", name, gcv, ecv); end
    checks++; if (idle0 !== pre_idle) begin failures++; $display("FAIL %s idle_before got=%b exp=%b", name, idle0, pre_idle); end
    checks++; if (idle1 !== m_idle) begin failures++; $display("FAIL %s card_idle got=%b exp=%b", name, idle1, m_idle); end
    checks++; if (idx1 !== m_idx) begin failures++; $display("FAIL %s cmd_index got=%0d exp=%0d", name, idx1, m_idx); end
    checks++; if (arg1 !== m_arg) begin failures++; $display("FAIL %s cmd_arg got=%h exp=%h", name, arg1, m_arg); end
    checks++; if (ce1 !== m_ce) begin failures++; $display("FAIL %s crc_err got=%b exp=%b", name, ce1, m_ce); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL reset miso got=%b exp=1", miso); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset card_idle got=%b exp=1", idle); end
    checks++; if (cv !== 1'b0) begin failures++; $display("FAIL reset cmd_valid got=%b exp=0", cv); end
    checks++; if (cidx !== 6'd0) begin failures++; $display("FAIL reset cmd_index got=%0d exp=0", cidx); end
    checks++; if (carg !== 32'h0) begin failures++; $display("FAIL reset cmd_arg got=%h exp=0", carg); end
    checks++; if (ce !== 1'b0) begin failures++; $display("FAIL reset crc_err got=%b exp=0", ce); end
  endtask

  task automatic test_cmd0();
    logic [39:0] got;
    xfer("cmd0", 48'h400000000095, 1'b0, 1'b0, got);
    checks++; if (got[39:32] !== 8'h01) begin failures++; $display("FAIL cmd0_r1 got=%h exp=01", got[39:32]); end
  endtask

  task automatic test_cmd8();
    logic [39:0] got;
    xfer("cmd8", 48'h48000001AA87, 1'b0, 1'b0, got);
    checks++; if (got !== 40'h01000001AA) begin failures++; $display("FAIL cmd8_r7 got=%h exp=01000001aa", got); end
  endtask

  task automatic test_init_sequence();
    logic [39:0] got;
    logic [7:0]  exp41;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      xfer("init_cmd55", mk_frame(6'd55, 32'h0, 1'b1), 1'b0, 1'b0, got);
      checks++; if (got[39:32] !== 8'h01) begin failures++; $display("FAIL init_cmd55_r1 got=%h exp=01", got[39:32]); end
      exp41 = (i < 3) ? 8'h01 : 8'h00;
      xfer("init_acmd41", mk_frame(6'd41, 32'h40000000, 1'b1), 1'b0, 1'b0, got);
      checks++; if (got[39:32] !== exp41) begin failures++; $display("FAIL init_acmd41_r1 got=%h exp=%h", got[39:32], exp41); end
    end
    xfer("init_cmd58", mk_frame(6'd58, 32'h0, 1'b1), 1'b0, 1'b0, got);
    checks++; if (got !== 40'h00C0FF8000) begin failures++; $display("FAIL init_cmd58_r3 got=%h exp=00c0ff8000", got); end
    xfer("init_cmd17", mk_frame(6'd17, 32'h0, 1'b1), 1'b0, 1'b0, got);
    checks++; if (got[39:32] !== 8'h04) begin failures++; $display("FAIL ready_cmd17_r1 got=%h exp=04", got[39:32]); end
  endtask

  task automatic test_reset_midtransfer();
    logic [39:0] got;
    logic [47:0] f;
    f = 48'h48000001AA87;
    for (int i = 47; i >= 18; i--) begin cs = 1'b0; din = f[i]; @(negedge clk); end
    rst = 1'b1; din = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midreset card_idle got=%b exp=1", idle); end
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL midreset miso got=%b exp=1", miso); end
    xfer("midreset_cmd58", mk_frame(6'd58, 32'h0, 1'b1), 1'b0, 1'b0, got);
    checks++; if (got !== 40'h0140FF8000) begin failures++; $display("FAIL midreset_cmd58_r3 got=%h exp=0140ff8000", got); end
  endtask

  task automatic test_crc_error();
    logic [39:0] got;
    apply_reset();
    xfer("crc_cmd0", 48'h400000000001, 1'b0, 1'b0, got);
    checks++; if (got[39:32] !== 8'h09) begin failures++; $display("FAIL crc_cmd0_r1 got=%h exp=09", got[39:32]); end
    xfer("crc_cmd8", mk_frame(6'd8, 32'h1AA, 1'b0), 1'b0, 1'b0, got);
    xfer("crc_cmd55_unchecked", mk_frame(6'd55, 32'h0, 1'b0), 1'b0, 1'b0, got);
    xfer("crc_acmd41", mk_frame(6'd41, 32'h0, 1'b1), 1'b0, 1'b0, got);
    checks++; if (got[39:32] !== 8'h01) begin failures++; $display("FAIL crc_acmd41_r1 got=%h exp=01", got[39:32]); end
  endtask

  task automatic test_illegal();
    logic [39:0] got;
    apply_reset();
    xfer("illegal_cmd41", mk_frame(6'd41, 32'h0, 1'b1), 1'b0, 1'b0, got);
    checks++; if (got[39:32] !== 8'h05) begin failures++; $display("FAIL illegal_cmd41_r1 got=%h exp=05", got[39:32]); end
    xfer("illegal_cmd17", mk_frame(6'd17, 32'h1234, 1'b1), 1'b0, 1'b0, got);
    checks++; if (got[39:32] !== 8'h05) begin failures++; $display("FAIL illegal_cmd17_r1 got=%h exp=05", got[39:32]); end
  endtask

  task automatic test_abort();
    logic [39:0] got;
    logic [47:0] f;
    bit          hi, quiet;
    apply_reset();
    hi = 1'b1; quiet = 1'b1;
    f = 48'h400000000095;
    for (int i = 47; i >= 28; i--) begin
      cs = 1'b0; din = f[i]; @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      cs = 1'b1; din = 1'b0; @(negedge clk);
      if (miso !== 1'b1) hi = 1'b0;
      if (cv !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!hi) begin failures++; $display("FAIL abort_rx miso got=0 exp=1"); end
    checks++; if (!quiet) begin failures++; $display("FAIL abort_rx cmd_valid got=1 exp=0"); end
    xfer("abort_cmd0", f, 1'b0, 1'b0, got);
    // drop CS exactly on the first gap clock: the complete CMD55 must be discarded
    f = mk_frame(6'd55, 32'h0, 1'b1);
    hi = 1'b1; quiet = 1'b1;
    for (int i = 47; i >= 0; i--) begin cs = 1'b0; din = f[i]; @(negedge clk); end
    for (int i = 0; i < 6; i++) begin
      cs = 1'b1; din = 1'b1; @(negedge clk);
      if (miso !== 1'b1) hi = 1'b0;
      if (cv !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!hi) begin failures++; $display("FAIL abort_ncr miso got=0 exp=1"); end
    checks++; if (!quiet) begin failures++; $display("FAIL abort_ncr cmd_valid got=1 exp=0"); end
    xfer("abort_cmd41", mk_frame(6'd41, 32'h0, 1'b1), 1'b0, 1'b0, got);
  endtask

  task automatic test_bad_framing();
    logic [39:0] got;
    xfer("frame_bit46", 48'h000000000095, 1'b0, 1'b0, got);
    xfer("frame_end",   48'h400000000094, 1'b0, 1'b0, got);
    xfer("frame_after", 48'h400000000095, 1'b0, 1'b0, got);
  endtask

  task automatic test_back_to_back();
    logic [39:0] got;
    apply_reset();
    xfer("b2b_cmd0",  48'h400000000095, 1'b0, 1'b1, got);
    xfer("b2b_cmd55", mk_frame(6'd55, 32'h0, 1'b1), 1'b1, 1'b1, got);
    xfer("b2b_cmd8",  48'h48000001AA87, 1'b1, 1'b0, got);
  endtask

  task automatic test_random();
    logic [39:0] got;
    logic [47:0] f;
    logic [31:0] arg;
    logic [5:0]  idx;
    int          sel, fr;
    bit          prev, b2b;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:         idx = 6'd0;
        1:         idx = 6'd8;
        2, 3, 4:   idx = 6'd55;
        5, 6, 7:   idx = 6'd41;
        8:         idx = 6'd58;
        default:   idx = 6'($urandom_range(0, 63));
      endcase
      arg = $urandom;
      if (idx == 6'd8 && $urandom_range(0, 1) == 1) arg[11:8] = 4'h1;
      f  = mk_frame(idx, arg, $urandom_range(0, 4) != 0);
      fr = $urandom_range(0, 11);
      if (fr == 0) f[46] = 1'b0;
      else if (fr == 1) f[0] = 1'b0;
      b2b = (i != 39) && ($urandom_range(0, 1) == 1);
      xfer("random", f, prev, b2b, got);
      prev = b2b;
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; din = 1'b1;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_init_sequence();
    test_reset_midtransfer();
    test_crc_error();
    test_illegal();
    test_abort();
    test_bad_framing();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
